// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with word-at-a-time refill.
// Define ICACHE_PERF_EN to add the hitCount/missCount performance counters.
module inst_cache #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imemAddr,
  output logic [31:0] imemData,
  output logic        imemStall,
  input  logic        flush,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memReady,
  input  logic        memRvalid,
  input  logic [31:0] memRdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hitCount,
  output logic [31:0] missCount
`endif
);

  localparam int WB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TW = 32 - IB - WB - 2;
  localparam logic [31:0]   NOP    = 32'h0000_0013;
  localparam logic [WB-1:0] K_LAST = WB'(WORDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t          state_r, state_nxt_s;
  logic [LINES-1:0] valid_r;
  logic [TW-1:0]   tag_arr_r [LINES];
  logic [31:0]     data_arr_r [LINES][WORDS];
  logic [WB-1:0]   k_r;
  logic [IB-1:0]   line_r;
  logic            flush_pend_r;
  logic            mem_req_r;
  logic [31:0]     mem_addr_r;

  logic [WB-1:0]   word_s;
  logic [IB-1:0]   idx_s;
  logic [TW-1:0]   tag_s;
  logic [31:0]     base_s;
  logic            hit_s, miss_s, rsp_s, last_s;
  logic            unused_addr_s;

  assign word_s        = imemAddr[WB+1:2];
  assign idx_s         = imemAddr[IB+WB+1:WB+2];
  assign tag_s         = imemAddr[31:IB+WB+2];
  assign base_s        = {imemAddr[31:WB+2], {(WB+2){1'b0}}};
  assign unused_addr_s = ^imemAddr[1:0];

  assign hit_s  = (state_r == IDLE) && valid_r[idx_s] && (tag_arr_r[idx_s] == tag_s);
  assign miss_s = (state_r == IDLE) && !hit_s;
  assign rsp_s  = (state_r == WAIT) && memRvalid;
  assign last_s = (k_r == K_LAST);

  assign imemStall = !hit_s;
  assign imemData  = hit_s ? data_arr_r[idx_s][word_s] : NOP;
  assign memReq    = mem_req_r;
  assign memAddr   = mem_addr_r;

  // Next-state logic of the refill sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = miss_s ? REQ : IDLE;
      REQ:     state_nxt_s = memReady ? WAIT : REQ;
      WAIT: begin
        if (memRvalid) begin
          state_nxt_s = last_s ? IDLE : REQ;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Sequencer state, request outputs, valid bits and deferred flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      valid_r      <= {LINES{1'b0}};
      k_r          <= {WB{1'b0}};
      line_r       <= {IB{1'b0}};
      flush_pend_r <= 1'b0;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= 32'h0000_0000;
    end else begin
      state_r   <= state_nxt_s;
      mem_req_r <= (state_nxt_s == REQ);
      case (state_r)
        IDLE: begin
          flush_pend_r <= 1'b0;
          if (miss_s) begin
            line_r     <= idx_s;
            k_r        <= {WB{1'b0}};
            mem_addr_r <= base_s;
          end
          // Flush wins over the single-line invalidate of a refill start.
          if (flush) begin
            valid_r <= {LINES{1'b0}};
          end else if (miss_s) begin
            valid_r[idx_s] <= 1'b0;
          end
        end
        REQ: begin
          if (flush) flush_pend_r <= 1'b1;
        end
        WAIT: begin
          if (rsp_s && last_s) begin
            flush_pend_r <= 1'b0;
            if (flush_pend_r || flush) begin
              valid_r <= {LINES{1'b0}};
            end else begin
              valid_r[line_r] <= 1'b1;
            end
          end else if (rsp_s) begin
            k_r          <= k_r + WB'(1);
            mem_addr_r   <= mem_addr_r + 32'd4;
            flush_pend_r <= flush_pend_r || flush;
          end else if (flush) begin
            flush_pend_r <= 1'b1;
          end
        end
        default: flush_pend_r <= 1'b0;
      endcase
    end
  end

  // Tag and data storage; intentionally not reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (miss_s) tag_arr_r[idx_s] <= tag_s;
      if (rsp_s) data_arr_r[line_r][k_r] <= memRdata;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_r, miss_cnt_r;

  assign hitCount  = hit_cnt_r;
  assign missCount = miss_cnt_r;

  // Free-running hit/miss counters; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_r  <= 32'd0;
      miss_cnt_r <= 32'd0;
    end else begin
      if (hit_s)  hit_cnt_r  <= hit_cnt_r + 32'd1;
      if (miss_s) miss_cnt_r <= miss_cnt_r + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: expected fetch data and refill addresses are queued
// by the stimulus and popped by independent monitors.
module tb_inst_cache;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic        imemStall;
  logic        flush;
  logic        memReq;
  logic [31:0] memAddr;
  logic        memReady;
  logic        memRvalid;
  logic [31:0] memRdata;
`ifdef ICACHE_PERF_EN
  logic [31:0] hitCount, missCount;
`endif

  inst_cache #(.LINES(16), .WORDS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .imemAddr  (imemAddr),
    .imemData  (imemData),
    .imemStall (imemStall),
    .flush     (flush),
    .memReq    (memReq),
    .memAddr   (memAddr),
    .memReady  (memReady),
    .memRvalid (memRvalid),
    .memRdata  (memRdata)
`ifdef ICACHE_PERF_EN
    ,
    .hitCount  (hitCount),
    .missCount (missCount)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic        mon_en = 1'b0;
  logic [31:0] slow_addr = 32'hFFFF_FFFF;
  logic [31:0] exp_data_q [$];
  logic [31:0] exp_addr_q [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) * 32'h11;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: actual=timeout/empty required=event", nm);
  endtask

  task automatic push_line(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_addr_q.push_back(base + 32'(4 * i));
  endtask

  // Issue one fetch and hold it until served; returns memReq seen in the first cycle.
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int exp_stall,
                       input string nm, output logic first_req);
    int   stalls;
    logic done;
    stalls = 0;
    done = 1'b0;
    first_req = 1'b0;
    exp_data_q.push_back(d);
    imemAddr = a;
    mon_en = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (c == 0) first_req = memReq;
      if (imemStall) begin
        stalls++;
        check({nm, "_nop"}, imemData, NOP);
      end else begin
        done = 1'b1;
        if (exp_stall == 0) check({nm, "_noreq"}, {31'd0, memReq}, 32'd0);
      end
    end
    if (!done) fail_now({nm, "_timeout"});
    check({nm, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    @(posedge clk);
    #1;
    mon_en = 1'b0;
  endtask

  // Backing memory: one request at a time, response one cycle after acceptance.
  initial begin
    logic [31:0] a;
    memRvalid = 1'b0;
    memRdata = 32'h0;
    forever begin
      @(negedge clk);
      if (memReq && memReady && !rst) begin
        a = memAddr;
        @(posedge clk);
        #1;
        if (a == slow_addr) begin
          memRvalid = 1'b0;
          @(posedge clk);
          #1;
        end
        memRvalid = 1'b1;
        memRdata = mem_word(a);
        @(posedge clk);
        #1;
        memRvalid = 1'b0;
      end
    end
  end

  // Fetch-data monitor.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && !imemStall) begin
        if (exp_data_q.size() == 0) begin
          fail_now("unexpected_hit");
        end else begin
          e = exp_data_q.pop_front();
          check("hit_data", imemData, e);
        end
      end
    end
  end

  // Refill-request monitor.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (memReq && memReady) begin
        if (exp_addr_q.size() == 0) begin
          fail_now("unexpected_req");
        end else begin
          e = exp_addr_q.pop_front();
          check("req_addr", memAddr, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic fr;
    logic found;
    rst = 1'b1;
    flush = 1'b0;
    memReady = 1'b1;
    imemAddr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_memReq", {31'd0, memReq}, 32'd0);
    check("rst_memAddr", memAddr, 32'h0);
    check("rst_stall", {31'd0, imemStall}, 32'd1);
    check("rst_data", imemData, NOP);
    @(posedge clk);
    #1;
    rst = 1'b0;

    push_line(32'h0, 4);
    fetch(32'h0, 32'h0, 9, "cold", fr);
    fetch(32'h4, 32'h11, 0, "hit4", fr);
    fetch(32'h8, 32'h22, 0, "hit8", fr);
    fetch(32'hC, 32'h33, 0, "hitC", fr);

    push_line(32'h100, 4);
    fetch(32'h100, 32'h440, 9, "conflict", fr);
    push_line(32'h0, 4);
    fetch(32'h0, 32'h0, 9, "refetch0", fr);
`ifdef ICACHE_PERF_EN
    check("missCount", missCount, 32'd3);
    check("hitCount", hitCount, 32'd6);
`endif

    // memReady low for the first five REQ cycles.
    memReady = 1'b0;
    push_line(32'h100, 4);
    fork
      fetch(32'h104, 32'h451, 14, "ready_low", fr);
      begin
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
          @(negedge clk);
          if (memReq) found = 1'b1;
        end
        if (!found) begin
          fail_now("ready_low_req");
        end else begin
          for (int i = 0; i < 5; i++) begin
            check("hold_memReq", {31'd0, memReq}, 32'd1);
            check("hold_memAddr", memAddr, 32'h100);
            @(posedge clk);
            #1;
            if (i < 4) @(negedge clk);
          end
        end
        memReady = 1'b1;
      end
    join

    // Flush during WAIT of word 1 forces a second refill.
    push_line(32'h0, 4);
    push_line(32'h0, 4);
    fork
      fetch(32'h0, 32'h0, 18, "flush", fr);
      begin
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
          @(negedge clk);
          if (memReq && memAddr == 32'h4) found = 1'b1;
        end
        if (!found) fail_now("flush_word1");
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
      end
    join

    // Reset during WAIT of word 2 with a late response.
    slow_addr = 32'h108;
    imemAddr = 32'h100;
    push_line(32'h100, 3);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (memReq && memAddr == 32'h108) found = 1'b1;
    end
    if (!found) fail_now("rst_word2");
    @(posedge clk);
    #1;
    rst = 1'b1;
    imemAddr = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_line(32'h0, 4);
    fetch(32'h0, 32'h0, 9, "post_rst", fr);
    check("post_rst_req", {31'd0, fr}, 32'd0);
    slow_addr = 32'hFFFF_FFFF;
    fetch(32'h8, 32'h22, 0, "post_rst_hit8", fr);

    check("data_q_empty", 32'(exp_data_q.size()), 32'd0);
    check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
